// File: rtl/dec_pkg.sv
// Shared constants, the one-hot word type and a reference decode helper for
// the binary-to-one-hot decoder family.
package dec_pkg;

  localparam int DEC_IN_W_DEFAULT  = 3;
  localparam int DEC_OUT_W_DEFAULT = 1 << DEC_IN_W_DEFAULT;

  typedef logic [DEC_OUT_W_DEFAULT-1:0] onehot_t;

  // Default-width decode: bit[code] set, all others clear.
  function automatic onehot_t onehot(input logic [DEC_IN_W_DEFAULT-1:0] code);
    onehot_t vec;
    vec       = '0;
    vec[code] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/dec_onehot.sv
// Combinational IN_W-to-OUT_W one-hot decode, gated by en.
// An all-zero result means "no select this cycle".
module dec_onehot #(
  parameter  int IN_W  = 3,
  localparam int OUT_W = 1 << IN_W
) (
  input  logic [IN_W-1:0]  in,
  input  logic             en,
  output logic [OUT_W-1:0] dec
);

  always_comb begin
    dec = '0;
    for (int i = 0; i < OUT_W; i++) begin
      dec[i] = en && (in == IN_W'(i));
    end
  end

endmodule

// File: rtl/dec_3to8.sv
// Registered binary-to-one-hot decoder with enable and an "any strobe" flag.
// Build option DEC_HOLD_EN: en=0 holds the previous out/active instead of clearing.
module dec_3to8
  import dec_pkg::*;
#(
  parameter  int IN_W  = DEC_IN_W_DEFAULT,
  localparam int OUT_W = 1 << IN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in,
  input  logic             en,
  output logic [OUT_W-1:0] out,
  output logic             active
);

  logic [OUT_W-1:0] dec;

  dec_onehot #(.IN_W(IN_W)) u_dec (
    .in  (in),
    .en  (en),
    .dec (dec)
  );

  // active is registered from the same decode so it always tracks |out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out    <= '0;
      active <= 1'b0;
    end else begin
`ifdef DEC_HOLD_EN
      if (en) begin
        out    <= dec;
        active <= |dec;
      end
`else
      out    <= dec;
      active <= |dec;
`endif
    end
  end

endmodule

// File: tb/tb_dec_3to8.sv
// Directed and randomized checks of dec_3to8 against an arithmetic reference model.
// Honours DEC_HOLD_EN the same way as the design build.
module tb_dec_3to8;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] in;
  logic       en;
  logic [7:0] out;
  logic       active;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] model_out;

  dec_3to8 dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
    .en     (en),
    .out    (out),
    .active (active)
  );

  always #5 clk = ~clk;

  // Reference: enabled code n selects the value 2**n; disabled clears or holds.
  function automatic logic [7:0] ref_next(input logic [7:0] prev, input int code, input logic e);
    if (e) return 8'(2 ** code);
`ifdef DEC_HOLD_EN
    return prev;
`else
    return (prev & 8'h00);
`endif
  endfunction

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input int code, input logic e);
    @(negedge clk);
    in        = 3'(code);
    en        = e;
    model_out = ref_next(model_out, code, e);
    exp_q.push_back(model_out);
  endtask

  task automatic edge_check(input string tag);
    logic [7:0] exp;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_queue: got empty expected entry", tag);
    end else begin
      exp = exp_q.pop_front();
      check8(tag, out, exp);
      check1({tag, "_active"}, active, (exp != 8'h00));
    end
  endtask

  initial begin
    rst       = 1'b1;
    in        = 3'd0;
    en        = 1'b0;
    model_out = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check8("reset_out", out, 8'h00);
    check1("reset_active", active, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Sweep every code with en=1.
    for (int i = 0; i < 8; i++) begin
      drive(i, 1'b1);
      edge_check($sformatf("sweep_%0d", i));
    end

    // Disable after in=7 decoded.
    drive(7, 1'b0);
    edge_check("disable");

    // Asynchronous reset mid-stream with out=80.
    drive(7, 1'b1);
    edge_check("pre_reset");
    #2;
    rst = 1'b1;
    #1;
    check8("async_reset_out", out, 8'h00);
    check1("async_reset_active", active, 1'b0);
    model_out = 8'h00;
    @(posedge clk);
    #1;
    check8("reset_held_out", out, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    drive(2, 1'b1);
    edge_check("post_reset");

    // Mid-cycle glitch on in, restored before the edge.
    drive(4, 1'b1);
    edge_check("glitch_setup");
    drive(6, 1'b1);
    #1;
    in = 3'd1;
    en = 1'b0;
    #1;
    check8("glitch_mid", out, 8'h10);
    in = 3'd6;
    en = 1'b1;
    edge_check("glitch");

    // Back-to-back codes with no intermediate zero.
    drive(3, 1'b1);
    edge_check("b2b_3");
    drive(5, 1'b1);
    edge_check("b2b_5");

    // Randomized run with invariant checks.
    for (int n = 0; n < 1000; n++) begin
      drive($urandom_range(0, 7), 1'($urandom_range(0, 1)));
      edge_check("rand");
      check1("rand_onehot", ($countones(out) <= 1), 1'b1);
      check1("rand_active_or", active, |out);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the bench cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
